// File: rtl/reg_bank_pkg.sv
// Shared defaults and types for the multi-port register bank and its load scoreboard.
package reg_bank_pkg;

    localparam int DW_DEF     = 32;
    localparam int NREGS_DEF  = 16;
    localparam int AW_DEF     = $clog2(NREGS_DEF);
    localparam int PC_IDX_DEF = 15;
    localparam int PC_OFS_DEF = 8;

    typedef logic [AW_DEF-1:0] reg_addr_t;
    typedef logic [DW_DEF-1:0] reg_data_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-load bits and the decode stall they produce.
module reg_scoreboard
    import reg_bank_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int AW     = $clog2(NREGS),
    parameter int NRD    = 3,
    parameter int PC_IDX = PC_IDX_DEF,
    parameter int BYPASS = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sb_set_i,
    input  logic [AW-1:0]     sb_idx_i,
    input  logic              we_b_i,
    input  logic [AW-1:0]     wa_b_i,
    input  logic [NRD*AW-1:0] ra_i,
    output logic              stall_o
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;

    // A new load issued on the same edge as the old one retires keeps the bit set.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NREGS; i++) begin
            if (we_b_i && wa_b_i == AW'(i))
                pending_d[i] = 1'b0;
            if (sb_set_i && sb_idx_i == AW'(i) && i != PC_IDX)
                pending_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            pending_q <= '0;
        else
            pending_q <= pending_d;
    end

    always_comb begin
        logic [AW-1:0] addr;
        stall_o = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            addr = ra_i[p*AW +: AW];
            if (int'(addr) < NREGS && pending_q[addr] &&
                !((BYPASS != 0) && we_b_i && wa_b_i == addr))
                stall_o = 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank_mp.sv
// Multi-port register bank: two write ports, NRD bypassed read ports, PC-relative R15 reads.
module reg_bank_mp
    import reg_bank_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int AW     = $clog2(NREGS),
    parameter int NRD    = 3,
    parameter int PC_IDX = PC_IDX_DEF,
    parameter int PC_OFS = PC_OFS_DEF,
    parameter int BYPASS = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_a_i,
    input  logic [AW-1:0]     wa_a_i,
    input  logic [DW-1:0]     wd_a_i,
    input  logic              we_b_i,
    input  logic [AW-1:0]     wa_b_i,
    input  logic [DW-1:0]     wd_b_i,
    input  logic [NRD*AW-1:0] ra_i,
    output logic [NRD*DW-1:0] rd_o,
    input  logic [DW-1:0]     pc_i,
    input  logic              sb_set_i,
    input  logic [AW-1:0]     sb_idx_i,
    output logic              stall_o,
    output logic              wr_clash_o
);

    logic [DW-1:0] rf_q [NREGS];
    logic [DW-1:0] rf_d [NREGS];
    logic          wr_clash_q;
    logic          wr_clash_d;

    // Port B (load) overrides port A on a shared address; the PC slot is never written.
    always_comb begin
        rf_d = rf_q;
        for (int i = 0; i < NREGS; i++) begin
            if (i != PC_IDX) begin
                if (we_b_i && wa_b_i == AW'(i))
                    rf_d[i] = wd_b_i;
                else if (we_a_i && wa_a_i == AW'(i))
                    rf_d[i] = wd_a_i;
            end
        end
        wr_clash_d = wr_clash_q | (we_a_i & we_b_i & (wa_a_i == wa_b_i));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++)
                rf_q[i] <= '0;
            wr_clash_q <= 1'b0;
        end else begin
            rf_q       <= rf_d;
            wr_clash_q <= wr_clash_d;
        end
    end

    assign wr_clash_o = wr_clash_q;

    always_comb begin
        logic [AW-1:0] addr;
        rd_o = '0;
        for (int p = 0; p < NRD; p++) begin
            addr = ra_i[p*AW +: AW];
            if (int'(addr) == PC_IDX)
                rd_o[p*DW +: DW] = pc_i + DW'(PC_OFS);
            else if (int'(addr) < NREGS) begin
                if ((BYPASS != 0) && we_b_i && wa_b_i == addr)
                    rd_o[p*DW +: DW] = wd_b_i;
                else if ((BYPASS != 0) && we_a_i && wa_a_i == addr)
                    rd_o[p*DW +: DW] = wd_a_i;
                else
                    rd_o[p*DW +: DW] = rf_q[addr];
            end
        end
    end

    reg_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW),
        .NRD   (NRD),
        .PC_IDX(PC_IDX),
        .BYPASS(BYPASS)
    ) u_scoreboard (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .sb_set_i(sb_set_i),
        .sb_idx_i(sb_idx_i),
        .we_b_i  (we_b_i),
        .wa_b_i  (wa_b_i),
        .ra_i    (ra_i),
        .stall_o (stall_o)
    );

endmodule

// File: tb/tb_reg_bank_mp.sv
// Directed self-checking bench for reg_bank_mp with hand-computed expected values.
module tb_reg_bank_mp;
    import reg_bank_pkg::*;

    logic      clk = 1'b0;
    logic      rstN;
    logic      weA, weB, sbSet;
    reg_addr_t waA, waB, sbIdx;
    reg_data_t wdA, wdB, pc;
    logic [11:0] ra;
    logic [95:0] rd;
    logic      stall, wrClash;

    int total = 0;
    int bad   = 0;

    reg_bank_mp dut (
        .clk_i     (clk),
        .rst_ni    (rstN),
        .we_a_i    (weA),
        .wa_a_i    (waA),
        .wd_a_i    (wdA),
        .we_b_i    (weB),
        .wa_b_i    (waB),
        .wd_b_i    (wdB),
        .ra_i      (ra),
        .rd_o      (rd),
        .pc_i      (pc),
        .sb_set_i  (sbSet),
        .sb_idx_i  (sbIdx),
        .stall_o   (stall),
        .wr_clash_o(wrClash)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic wea, input reg_addr_t waa, input reg_data_t wda,
                                 input logic web, input reg_addr_t wab, input reg_data_t wdb,
                                 input logic sbs, input reg_addr_t sbi);
        weA = wea; waA = waa; wdA = wda;
        weB = web; waB = wab; wdB = wdb;
        sbSet = sbs; sbIdx = sbi;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
    endtask

    initial begin
        rstN = 1'b0;
        pc   = 32'd0;
        ra   = 12'd0;
        idle();
        #12;
        checkOutput("reset_rd0", rd[31:0], 32'd0);
        checkOutput("reset_stall", {31'd0, stall}, 32'd0);
        rstN = 1'b1;
        tick();

        // Same-cycle bypass, then stored value
        ra = {4'd0, 4'd0, 4'd3};
        applyStimulus(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        checkOutput("bypass_a", rd[31:0], 32'hDEAD_BEEF);
        checkOutput("other_port_r0", rd[63:32], 32'd0);
        tick();
        idle();
        checkOutput("stored_r3", rd[31:0], 32'hDEAD_BEEF);

        // Write clash on R5
        ra = {4'd0, 4'd0, 4'd5};
        applyStimulus(1'b1, 4'd5, 32'd1, 1'b1, 4'd5, 32'd2, 1'b0, 4'd0);
        checkOutput("clash_bypass_b", rd[31:0], 32'd2);
        checkOutput("clash_before_edge", {31'd0, wrClash}, 32'd0);
        tick();
        idle();
        checkOutput("clash_stored_r5", rd[31:0], 32'd2);
        checkOutput("clash_flag", {31'd0, wrClash}, 32'd1);
        tick();
        checkOutput("clash_sticky", {31'd0, wrClash}, 32'd1);

        // PC reads and dropped PC write
        ra = {4'd0, 4'd15, 4'd3};
        pc = 32'h0000_0100;
        applyStimulus(1'b1, 4'd15, 32'd7, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        checkOutput("pc_read", rd[63:32], 32'h0000_0108);
        tick();
        idle();
        pc = 32'd0;
        #1;
        checkOutput("pc_slot_unchanged", rd[63:32], 32'd8);
        pc = 32'hFFFF_FFFC;
        #1;
        checkOutput("pc_wrap", rd[63:32], 32'h0000_0004);
        pc = 32'd0;

        // Scoreboard on R4
        ra = {4'd4, 4'd0, 4'd0};
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd4);
        checkOutput("sb_not_yet", {31'd0, stall}, 32'd0);
        tick();
        idle();
        checkOutput("sb_stall", {31'd0, stall}, 32'd1);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 32'd9, 1'b0, 4'd0);
        checkOutput("sb_bypass_unstall", {31'd0, stall}, 32'd0);
        checkOutput("sb_bypass_data", rd[95:64], 32'd9);
        tick();
        idle();
        checkOutput("sb_cleared", {31'd0, stall}, 32'd0);
        checkOutput("sb_stored_r4", rd[95:64], 32'd9);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 32'h0000_000A, 1'b1, 4'd4);
        tick();
        idle();
        checkOutput("sb_set_wins", {31'd0, stall}, 32'd1);
        checkOutput("sb_set_wins_data", rd[95:64], 32'h0000_000A);

        // Port A does not retire a pending load
        applyStimulus(1'b1, 4'd4, 32'h0000_0055, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        checkOutput("sb_porta_still_stall", {31'd0, stall}, 32'd1);
        checkOutput("sb_porta_bypass", rd[95:64], 32'h0000_0055);
        tick();
        idle();
        checkOutput("sb_porta_no_clear", {31'd0, stall}, 32'd1);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 32'd9, 1'b0, 4'd0);
        tick();
        idle();
        checkOutput("sb_retired", {31'd0, stall}, 32'd0);

        // Loads into the PC slot never mark pending
        ra = {4'd0, 4'd0, 4'd15};
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd15);
        tick();
        idle();
        checkOutput("sb_pc_ignored", {31'd0, stall}, 32'd0);

        // Mid-cycle reset discards pending writes and loads
        ra = {4'd6, 4'd5, 4'd3};
        applyStimulus(1'b1, 4'd6, 32'h1234_5678, 1'b0, 4'd0, 32'd0, 1'b1, 4'd6);
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("rst_async_r3", rd[31:0], 32'd0);
        checkOutput("rst_async_clash", {31'd0, wrClash}, 32'd0);
        idle();
        tick();
        rstN = 1'b1;
        tick();
        checkOutput("rst_r3", rd[31:0], 32'd0);
        checkOutput("rst_r5", rd[63:32], 32'd0);
        checkOutput("rst_r6", rd[95:64], 32'd0);
        checkOutput("rst_stall", {31'd0, stall}, 32'd0);
        checkOutput("rst_clash", {31'd0, wrClash}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
